// File: rtl/fib_bcd_conv.sv
// fib_bcd_conv: captures Fibonacci terms on in_valid and converts them to packed BCD
// with a bit-serial shift-add-3 engine. While busy, one pending term is held; the
// latest strobe wins.
module fib_bcd_conv #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    bcd_sr;
  logic [CW-1:0]    cnt;
  logic             pend;
  logic [WIDTH-1:0] pend_data;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    nxt_bcd;
  logic [WIDTH-1:0] nxt_bin;
  logic [WIDTH-1:0] restart_data;

  // Per-digit add-3 correction; 4-bit, no carry between digits.
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign adj[4*d +: 4] = (bcd_sr[4*d +: 4] >= 4'd5) ? bcd_sr[4*d +: 4] + 4'd3
                                                       : bcd_sr[4*d +: 4];
  end

  // One left shift of {bcd,bin}; the bit leaving the top digit is dropped.
  assign nxt_bcd = {adj[BW-2:0], bin_sr[WIDTH-1]};
  assign nxt_bin = {bin_sr[WIDTH-2:0], 1'b0};

  // A strobe landing in DONE is newer than anything pending, so it takes priority.
  assign restart_data = in_valid ? in_data : pend_data;

  // Conversion FSM with registered outputs and single-entry pending slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      bcd_out   <= '0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_data <= '0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr <= in_data;
            bcd_sr <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= nxt_bcd;
          bin_sr <= nxt_bin;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
          if (in_valid) begin
            pend      <= 1'b1;
            pend_data <= in_data;
          end
        end
        DONE: begin
          bcd_out   <= bcd_sr;
          bcd_valid <= 1'b1;
          if (pend || in_valid) begin
            bin_sr <= restart_data;
            bcd_sr <= '0;
            cnt    <= CW'(WIDTH);
            pend   <= 1'b0;
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_bcd_conv.sv
// tb_fib_bcd_conv: directed checks of binary->BCD conversion, latency, pending
// overwrite, async reset abort and a full Fibonacci sequence.
module tb_fib_bcd_conv;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd_out;

  int checks = 0;
  int errors = 0;

  fib_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .busy     (busy),
    .bcd_valid(bcd_valid),
    .bcd_out  (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference BCD via repeated division (independent of shift-add-3).
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Strobe one term; returns after edge E0 (+1).
  task automatic strobe(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after E0 until bcd_valid is seen; 99 on timeout.
  task automatic wait_valid(output int lat);
    lat = 99;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bcd_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic conv(input string tag, input logic [15:0] d, input logic [19:0] exp);
    int lat;
    strobe(d);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 17);
    chk({tag, "_bcd"}, bcd_out, exp);
    @(posedge clk); #1;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat, vcnt, busy_bad, v17, v34;
    logic [19:0] o17, o34;
    int unsigned a, b, t;

    in_valid = 1'b0;
    in_data  = '0;
    rst      = 1'b0;

    // 1. reset state, no strobes
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", bcd_valid, 0);
    chk("rst_bcd", bcd_out, 0);
    rst = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bcd_valid) vcnt++;
    end
    chk("idle_novalid", vcnt, 0);
    chk("idle_bcd", bcd_out, 0);
    chk("idle_busy", busy, 0);

    // 2,3. single conversions
    conv("zero", 16'd0, 20'h00000);
    conv("f1597", 16'h063D, 20'h01597);
    conv("max", 16'd65535, 20'h65535);
    conv("f46368", 16'd46368, 20'h46368);

    // 4. overlapping strobes: 377 overwritten by 610
    strobe(16'd233);
    vcnt = 0; busy_bad = 0; v17 = 0; v34 = 0; o17 = '0; o34 = '0;
    for (int c = 1; c <= 45; c++) begin
      in_valid = (c == 5) || (c == 9);
      in_data  = (c == 5) ? 16'd377 : 16'd610;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (c <= 33 && !busy) busy_bad++;
      if (bcd_valid) begin
        vcnt++;
        if (c == 17) begin v17 = 1; o17 = bcd_out; end
        if (c == 34) begin v34 = 1; o34 = bcd_out; end
      end
    end
    chk("ovl_v17", v17, 1);
    chk("ovl_o17", o17, 20'h00233);
    chk("ovl_v34", v34, 1);
    chk("ovl_o34", o34, 20'h00610);
    chk("ovl_count", vcnt, 2);
    chk("ovl_busy", busy_bad, 0);
    chk("ovl_end_busy", busy, 0);

    // 5. reset mid-conversion aborts
    strobe(16'd28657);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_valid", bcd_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bcd_valid) vcnt++;
    end
    chk("abort_novalid", vcnt, 0);
    chk("abort_bcd2", bcd_out, 0);
    conv("f89", 16'd89, 20'h00089);

    // 6. full Fibonacci run
    a = 0; b = 1;
    while (a <= 65535) begin
      strobe(16'(a));
      wait_valid(lat);
      chk($sformatf("fib%0d_lat", a), lat, 17);
      chk($sformatf("fib%0d_bcd", a), bcd_out, ref_bcd(a));
      vcnt = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (bcd_valid) vcnt++;
      end
      chk($sformatf("fib%0d_once", a), vcnt, 0);
      t = a + b; a = b; b = t;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
